axi4_mst_arb: RTL and testbench

AXI4_MST_ARB -- requirements
Module: axi4_mst_arb

---
 rtl/axi4_mst_arb.sv | 218 +++++++++++++++++++++
 tb/tb_axi4_mst_arb.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mst_arb.sv
// Two-master to one-slave AXI4 arbiter for single-beat traffic. Write and read
// paths arbitrate independently with round-robin; responses route by ID MSB.
module axi4_mst_arb #(
  parameter int TAG = 1
) (
  input  logic           clk,
  input  logic           rst_l,
  // master 0
  input  logic           m0_axi_awvalid,
  output logic           m0_axi_awready,
  input  logic [TAG-1:0] m0_axi_awid,
  input  logic [31:0]    m0_axi_awaddr,
  input  logic [2:0]     m0_axi_awsize,
  input  logic [2:0]     m0_axi_awprot,
  input  logic [7:0]     m0_axi_awlen,
  input  logic [1:0]     m0_axi_awburst,
  input  logic           m0_axi_wvalid,
  output logic           m0_axi_wready,
  input  logic [63:0]    m0_axi_wdata,
  input  logic [7:0]     m0_axi_wstrb,
  input  logic           m0_axi_wlast,
  output logic           m0_axi_bvalid,
  input  logic           m0_axi_bready,
  output logic [1:0]     m0_axi_bresp,
  output logic [TAG-1:0] m0_axi_bid,
  input  logic           m0_axi_arvalid,
  output logic           m0_axi_arready,
  input  logic [TAG-1:0] m0_axi_arid,
  input  logic [31:0]    m0_axi_araddr,
  input  logic [2:0]     m0_axi_arsize,
  input  logic [2:0]     m0_axi_arprot,
  input  logic [7:0]     m0_axi_arlen,
  input  logic [1:0]     m0_axi_arburst,
  output logic           m0_axi_rvalid,
  input  logic           m0_axi_rready,
  output logic [TAG-1:0] m0_axi_rid,
  output logic [63:0]    m0_axi_rdata,
  output logic [1:0]     m0_axi_rresp,
  output logic           m0_axi_rlast,
  // master 1
  input  logic           m1_axi_awvalid,
  output logic           m1_axi_awready,
  input  logic [TAG-1:0] m1_axi_awid,
  input  logic [31:0]    m1_axi_awaddr,
  input  logic [2:0]     m1_axi_awsize,
  input  logic [2:0]     m1_axi_awprot,
  input  logic [7:0]     m1_axi_awlen,
  input  logic [1:0]     m1_axi_awburst,
  input  logic           m1_axi_wvalid,
  output logic           m1_axi_wready,
  input  logic [63:0]    m1_axi_wdata,
  input  logic [7:0]     m1_axi_wstrb,
  input  logic           m1_axi_wlast,
  output logic           m1_axi_bvalid,
  input  logic           m1_axi_bready,
  output logic [1:0]     m1_axi_bresp,
  output logic [TAG-1:0] m1_axi_bid,
  input  logic           m1_axi_arvalid,
  output logic           m1_axi_arready,
  input  logic [TAG-1:0] m1_axi_arid,
  input  logic [31:0]    m1_axi_araddr,
  input  logic [2:0]     m1_axi_arsize,
  input  logic [2:0]     m1_axi_arprot,
  input  logic [7:0]     m1_axi_arlen,
  input  logic [1:0]     m1_axi_arburst,
  output logic           m1_axi_rvalid,
  input  logic           m1_axi_rready,
  output logic [TAG-1:0] m1_axi_rid,
  output logic [63:0]    m1_axi_rdata,
  output logic [1:0]     m1_axi_rresp,
  output logic           m1_axi_rlast,
  // downstream slave
  output logic           axi_awvalid,
  input  logic           axi_awready,
  output logic [TAG:0]   axi_awid,
  output logic [31:0]    axi_awaddr,
  output logic [2:0]     axi_awsize,
  output logic [2:0]     axi_awprot,
  output logic [7:0]     axi_awlen,
  output logic [1:0]     axi_awburst,
  output logic           axi_wvalid,
  input  logic           axi_wready,
  output logic [63:0]    axi_wdata,
  output logic [7:0]     axi_wstrb,
  output logic           axi_wlast,
  input  logic           axi_bvalid,
  output logic           axi_bready,
  input  logic [1:0]     axi_bresp,
  input  logic [TAG:0]   axi_bid,
  output logic           axi_arvalid,
  input  logic           axi_arready,
  output logic [TAG:0]   axi_arid,
  output logic [31:0]    axi_araddr,
  output logic [2:0]     axi_arsize,
  output logic [2:0]     axi_arprot,
  output logic [7:0]     axi_arlen,
  output logic [1:0]     axi_arburst,
  input  logic           axi_rvalid,
  output logic           axi_rready,
  input  logic [TAG:0]   axi_rid,
  input  logic [63:0]    axi_rdata,
  input  logic [1:0]     axi_rresp,
  input  logic           axi_rlast
);

  localparam logic [0:0] WIDLE = 1'b0, WBUSY = 1'b1;
  localparam logic [0:0] RIDLE = 1'b0, RBUSY = 1'b1;

  logic [0:0] wst_q, wst_d, rst_q, rst_d;
  logic wgnt_q, wgnt_d, last_wr_q, last_wr_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rgnt_q, rgnt_d, last_rd_q, last_rd_d;
  logic wreq0, wreq1, wbusy, aw_hs, w_hs, s_awvalid, s_wvalid;
  logic rbusy, s_arvalid;

  // Address without data is not a request: data must travel with the address.
  assign wreq0 = m0_axi_awvalid & m0_axi_wvalid;
  assign wreq1 = m1_axi_awvalid & m1_axi_wvalid;
  assign wbusy = (wst_q == WBUSY);
  assign rbusy = (rst_q == RBUSY);

  assign s_awvalid   = wgnt_q ? m1_axi_awvalid : m0_axi_awvalid;
  assign s_wvalid    = wgnt_q ? m1_axi_wvalid  : m0_axi_wvalid;
  assign axi_awvalid = wbusy & s_awvalid & ~aw_done_q;
  assign axi_wvalid  = wbusy & s_wvalid  & ~w_done_q;
  assign axi_awid    = {wgnt_q, wgnt_q ? m1_axi_awid : m0_axi_awid};
  assign axi_awaddr  = wgnt_q ? m1_axi_awaddr  : m0_axi_awaddr;
  assign axi_awsize  = wgnt_q ? m1_axi_awsize  : m0_axi_awsize;
  assign axi_awprot  = wgnt_q ? m1_axi_awprot  : m0_axi_awprot;
  assign axi_awlen   = wgnt_q ? m1_axi_awlen   : m0_axi_awlen;
  assign axi_awburst = wgnt_q ? m1_axi_awburst : m0_axi_awburst;
  assign axi_wdata   = wgnt_q ? m1_axi_wdata   : m0_axi_wdata;
  assign axi_wstrb   = wgnt_q ? m1_axi_wstrb   : m0_axi_wstrb;
  assign axi_wlast   = wgnt_q ? m1_axi_wlast   : m0_axi_wlast;
  assign aw_hs       = axi_awvalid & axi_awready;
  assign w_hs        = axi_wvalid & axi_wready;

  assign m0_axi_awready = wbusy & ~wgnt_q & ~aw_done_q & axi_awready;
  assign m1_axi_awready = wbusy &  wgnt_q & ~aw_done_q & axi_awready;
  assign m0_axi_wready  = wbusy & ~wgnt_q & ~w_done_q & axi_wready;
  assign m1_axi_wready  = wbusy &  wgnt_q & ~w_done_q & axi_wready;

  always_comb begin
    wst_d = wst_q; wgnt_d = wgnt_q; last_wr_d = last_wr_q;
    aw_done_d = aw_done_q; w_done_d = w_done_q;
    case (wst_q)
      WIDLE: if (wreq0 | wreq1) begin
        wgnt_d    = (wreq0 & wreq1) ? ~last_wr_q : wreq1;
        last_wr_d = (wreq0 & wreq1) ? ~last_wr_q : wreq1;
        wst_d     = WBUSY;
      end
      WBUSY: if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
        wst_d = WIDLE; aw_done_d = 1'b0; w_done_d = 1'b0;
      end else begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
      end
      default: wst_d = WIDLE;
    endcase
  end

  assign s_arvalid      = rgnt_q ? m1_axi_arvalid : m0_axi_arvalid;
  assign axi_arvalid    = rbusy & s_arvalid;
  assign axi_arid       = {rgnt_q, rgnt_q ? m1_axi_arid : m0_axi_arid};
  assign axi_araddr     = rgnt_q ? m1_axi_araddr  : m0_axi_araddr;
  assign axi_arsize     = rgnt_q ? m1_axi_arsize  : m0_axi_arsize;
  assign axi_arprot     = rgnt_q ? m1_axi_arprot  : m0_axi_arprot;
  assign axi_arlen      = rgnt_q ? m1_axi_arlen   : m0_axi_arlen;
  assign axi_arburst    = rgnt_q ? m1_axi_arburst : m0_axi_arburst;
  assign m0_axi_arready = rbusy & ~rgnt_q & axi_arready;
  assign m1_axi_arready = rbusy &  rgnt_q & axi_arready;

  always_comb begin
    rst_d = rst_q; rgnt_d = rgnt_q; last_rd_d = last_rd_q;
    case (rst_q)
      RIDLE: if (m0_axi_arvalid | m1_axi_arvalid) begin
        rgnt_d    = (m0_axi_arvalid & m1_axi_arvalid) ? ~last_rd_q : m1_axi_arvalid;
        last_rd_d = (m0_axi_arvalid & m1_axi_arvalid) ? ~last_rd_q : m1_axi_arvalid;
        rst_d     = RBUSY;
      end
      RBUSY: if (axi_arvalid & axi_arready) rst_d = RIDLE;
      default: rst_d = RIDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wst_q <= WIDLE; wgnt_q <= 1'b0; last_wr_q <= 1'b1;
      aw_done_q <= 1'b0; w_done_q <= 1'b0;
      rst_q <= RIDLE; rgnt_q <= 1'b0; last_rd_q <= 1'b1;
    end else begin
      wst_q <= wst_d; wgnt_q <= wgnt_d; last_wr_q <= last_wr_d;
      aw_done_q <= aw_done_d; w_done_q <= w_done_d;
      rst_q <= rst_d; rgnt_q <= rgnt_d; last_rd_q <= last_rd_d;
    end
  end

  // Stateless response routing; gated by reset so nothing leaks upstream.
  assign m0_axi_bvalid = rst_l & axi_bvalid & ~axi_bid[TAG];
  assign m1_axi_bvalid = rst_l & axi_bvalid &  axi_bid[TAG];
  assign axi_bready    = rst_l & (axi_bid[TAG] ? m1_axi_bready : m0_axi_bready);
  assign m0_axi_bresp  = axi_bresp;
  assign m1_axi_bresp  = axi_bresp;
  assign m0_axi_bid    = axi_bid[TAG-1:0];
  assign m1_axi_bid    = axi_bid[TAG-1:0];

  assign m0_axi_rvalid = rst_l & axi_rvalid & ~axi_rid[TAG];
  assign m1_axi_rvalid = rst_l & axi_rvalid &  axi_rid[TAG];
  assign axi_rready    = rst_l & (axi_rid[TAG] ? m1_axi_rready : m0_axi_rready);
  assign m0_axi_rid    = axi_rid[TAG-1:0];
  assign m1_axi_rid    = axi_rid[TAG-1:0];
  assign m0_axi_rdata  = axi_rdata;
  assign m1_axi_rdata  = axi_rdata;
  assign m0_axi_rresp  = axi_rresp;
  assign m1_axi_rresp  = axi_rresp;
  assign m0_axi_rlast  = axi_rlast;
  assign m1_axi_rlast  = axi_rlast;

endmodule

// File: tb/tb_axi4_mst_arb.sv
// Bench for axi4_mst_arb: response-routing vector table plus scoreboarded
// arbitration sequences (ties, split handshakes, aw-only hold-off, reset abort).
module tb_axi4_mst_arb;
  localparam int TAG = 1;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  logic m0_axi_awvalid, m0_axi_awready, m0_axi_wvalid, m0_axi_wready, m0_axi_wlast;
  logic m0_axi_bvalid, m0_axi_bready, m0_axi_arvalid, m0_axi_arready;
  logic m0_axi_rvalid, m0_axi_rready, m0_axi_rlast;
  logic [TAG-1:0] m0_axi_awid, m0_axi_bid, m0_axi_arid, m0_axi_rid;
  logic [31:0] m0_axi_awaddr, m0_axi_araddr;
  logic [2:0] m0_axi_awsize, m0_axi_awprot, m0_axi_arsize, m0_axi_arprot;
  logic [7:0] m0_axi_awlen, m0_axi_arlen, m0_axi_wstrb;
  logic [1:0] m0_axi_awburst, m0_axi_arburst, m0_axi_bresp, m0_axi_rresp;
  logic [63:0] m0_axi_wdata, m0_axi_rdata;

  logic m1_axi_awvalid, m1_axi_awready, m1_axi_wvalid, m1_axi_wready, m1_axi_wlast;
  logic m1_axi_bvalid, m1_axi_bready, m1_axi_arvalid, m1_axi_arready;
  logic m1_axi_rvalid, m1_axi_rready, m1_axi_rlast;
  logic [TAG-1:0] m1_axi_awid, m1_axi_bid, m1_axi_arid, m1_axi_rid;
  logic [31:0] m1_axi_awaddr, m1_axi_araddr;
  logic [2:0] m1_axi_awsize, m1_axi_awprot, m1_axi_arsize, m1_axi_arprot;
  logic [7:0] m1_axi_awlen, m1_axi_arlen, m1_axi_wstrb;
  logic [1:0] m1_axi_awburst, m1_axi_arburst, m1_axi_bresp, m1_axi_rresp;
  logic [63:0] m1_axi_wdata, m1_axi_rdata;

  logic axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast;
  logic axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast;
  logic [TAG:0] axi_awid, axi_bid, axi_arid, axi_rid;
  logic [31:0] axi_awaddr, axi_araddr;
  logic [2:0] axi_awsize, axi_awprot, axi_arsize, axi_arprot;
  logic [7:0] axi_awlen, axi_arlen, axi_wstrb;
  logic [1:0] axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic [63:0] axi_wdata, axi_rdata;

  axi4_mst_arb #(.TAG(TAG)) dut (
    .clk(clk), .rst_l(rst_l),
    .m0_axi_awvalid(m0_axi_awvalid), .m0_axi_awready(m0_axi_awready), .m0_axi_awid(m0_axi_awid),
    .m0_axi_awaddr(m0_axi_awaddr), .m0_axi_awsize(m0_axi_awsize), .m0_axi_awprot(m0_axi_awprot),
    .m0_axi_awlen(m0_axi_awlen), .m0_axi_awburst(m0_axi_awburst),
    .m0_axi_wvalid(m0_axi_wvalid), .m0_axi_wready(m0_axi_wready), .m0_axi_wdata(m0_axi_wdata),
    .m0_axi_wstrb(m0_axi_wstrb), .m0_axi_wlast(m0_axi_wlast),
    .m0_axi_bvalid(m0_axi_bvalid), .m0_axi_bready(m0_axi_bready), .m0_axi_bresp(m0_axi_bresp),
    .m0_axi_bid(m0_axi_bid),
    .m0_axi_arvalid(m0_axi_arvalid), .m0_axi_arready(m0_axi_arready), .m0_axi_arid(m0_axi_arid),
    .m0_axi_araddr(m0_axi_araddr), .m0_axi_arsize(m0_axi_arsize), .m0_axi_arprot(m0_axi_arprot),
    .m0_axi_arlen(m0_axi_arlen), .m0_axi_arburst(m0_axi_arburst),
    .m0_axi_rvalid(m0_axi_rvalid), .m0_axi_rready(m0_axi_rready), .m0_axi_rid(m0_axi_rid),
    .m0_axi_rdata(m0_axi_rdata), .m0_axi_rresp(m0_axi_rresp), .m0_axi_rlast(m0_axi_rlast),
    .m1_axi_awvalid(m1_axi_awvalid), .m1_axi_awready(m1_axi_awready), .m1_axi_awid(m1_axi_awid),
    .m1_axi_awaddr(m1_axi_awaddr), .m1_axi_awsize(m1_axi_awsize), .m1_axi_awprot(m1_axi_awprot),
    .m1_axi_awlen(m1_axi_awlen), .m1_axi_awburst(m1_axi_awburst),
    .m1_axi_wvalid(m1_axi_wvalid), .m1_axi_wready(m1_axi_wready), .m1_axi_wdata(m1_axi_wdata),
    .m1_axi_wstrb(m1_axi_wstrb), .m1_axi_wlast(m1_axi_wlast),
    .m1_axi_bvalid(m1_axi_bvalid), .m1_axi_bready(m1_axi_bready), .m1_axi_bresp(m1_axi_bresp),
    .m1_axi_bid(m1_axi_bid),
    .m1_axi_arvalid(m1_axi_arvalid), .m1_axi_arready(m1_axi_arready), .m1_axi_arid(m1_axi_arid),
    .m1_axi_araddr(m1_axi_araddr), .m1_axi_arsize(m1_axi_arsize), .m1_axi_arprot(m1_axi_arprot),
    .m1_axi_arlen(m1_axi_arlen), .m1_axi_arburst(m1_axi_arburst),
    .m1_axi_rvalid(m1_axi_rvalid), .m1_axi_rready(m1_axi_rready), .m1_axi_rid(m1_axi_rid),
    .m1_axi_rdata(m1_axi_rdata), .m1_axi_rresp(m1_axi_rresp), .m1_axi_rlast(m1_axi_rlast),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
    .axi_awaddr(axi_awaddr), .axi_awsize(axi_awsize), .axi_awprot(axi_awprot),
    .axi_awlen(axi_awlen), .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
    .axi_araddr(axi_araddr), .axi_arsize(axi_arsize), .axi_arprot(axi_arprot),
    .axi_arlen(axi_arlen), .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast)
  );

  typedef struct {
    logic       bv;
    logic [1:0] bid;
    logic [1:0] bresp;
    logic       rv;
    logic [1:0] rid;
    logic [1:0] rresp;
    logic [3:0] rdy;     // {m1_rready, m0_rready, m1_bready, m0_bready}
    logic [1:0] e_bv;    // {m1, m0}
    logic [1:0] e_rv;    // {m1, m0}
    logic       e_bready;
    logic       e_rready;
    logic       e_bid;
    logic       e_rid;
    logic [1:0] e_rresp;
  } rsp_t;

  int checks = 0;
  int errors = 0;
  logic [33:0] q_aw[$];
  logic [33:0] q_ar[$];
  logic [63:0] q_w[$];
  rsp_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected no transfer", nm, act);
  endtask

  task automatic wr(input int m, input logic id, input logic [31:0] a, input logic [63:0] d);
    if (m == 0) begin
      m0_axi_awvalid = 1'b1; m0_axi_awid = id; m0_axi_awaddr = a;
      m0_axi_wvalid = 1'b1; m0_axi_wdata = d;
    end else begin
      m1_axi_awvalid = 1'b1; m1_axi_awid = id; m1_axi_awaddr = a;
      m1_axi_wvalid = 1'b1; m1_axi_wdata = d;
    end
    q_aw.push_back({(m == 1), id, a});
    q_w.push_back(d);
  endtask

  task automatic rd(input int m, input logic id, input logic [31:0] a);
    if (m == 0) begin
      m0_axi_arvalid = 1'b1; m0_axi_arid = id; m0_axi_araddr = a;
    end else begin
      m1_axi_arvalid = 1'b1; m1_axi_arid = id; m1_axi_araddr = a;
    end
    q_ar.push_back({(m == 1), id, a});
  endtask

  // Score downstream handshakes before the edge, then retire upstream beats after it.
  task automatic step();
    logic h0aw, h0w, h1aw, h1w, h0ar, h1ar;
    #1;
    if (axi_awvalid && axi_awready) begin
      if (q_aw.size() == 0) unexpected("sb_aw_extra", {axi_awid, axi_awaddr});
      else chk("sb_aw", {axi_awid, axi_awaddr}, q_aw.pop_front());
    end
    if (axi_wvalid && axi_wready) begin
      if (q_w.size() == 0) unexpected("sb_w_extra", axi_wdata);
      else chk("sb_w", axi_wdata, q_w.pop_front());
    end
    if (axi_arvalid && axi_arready) begin
      if (q_ar.size() == 0) unexpected("sb_ar_extra", {axi_arid, axi_araddr});
      else chk("sb_ar", {axi_arid, axi_araddr}, q_ar.pop_front());
    end
    h0aw = m0_axi_awvalid & m0_axi_awready; h0w = m0_axi_wvalid & m0_axi_wready;
    h1aw = m1_axi_awvalid & m1_axi_awready; h1w = m1_axi_wvalid & m1_axi_wready;
    h0ar = m0_axi_arvalid & m0_axi_arready; h1ar = m1_axi_arvalid & m1_axi_arready;
    @(posedge clk);
    #1;
    if (h0aw) m0_axi_awvalid = 1'b0;
    if (h0w)  m0_axi_wvalid  = 1'b0;
    if (h1aw) m1_axi_awvalid = 1'b0;
    if (h1w)  m1_axi_wvalid  = 1'b0;
    if (h0ar) m0_axi_arvalid = 1'b0;
    if (h1ar) m1_axi_arvalid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0001, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[1] = '{1'b1, 2'b11, 2'b01, 1'b0, 2'b00, 2'b00, 4'b0010, 2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
    tbl[2] = '{1'b0, 2'b10, 2'b00, 1'b1, 2'b11, 2'b10, 4'b1000, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10};
    tbl[3] = '{1'b1, 2'b01, 2'b00, 1'b1, 2'b01, 2'b11, 4'b0100, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11};
    tbl[4] = '{1'b1, 2'b10, 2'b01, 1'b1, 2'b00, 2'b00, 4'b1010, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};

    {m0_axi_awvalid, m0_axi_wvalid, m0_axi_arvalid, m0_axi_bready, m0_axi_rready} = '0;
    {m1_axi_awvalid, m1_axi_wvalid, m1_axi_arvalid, m1_axi_bready, m1_axi_rready} = '0;
    m0_axi_awid = '0; m0_axi_awaddr = '0; m0_axi_arid = '0; m0_axi_araddr = '0; m0_axi_wdata = '0;
    m1_axi_awid = '0; m1_axi_awaddr = '0; m1_axi_arid = '0; m1_axi_araddr = '0; m1_axi_wdata = '0;
    m0_axi_awsize = 3'd3; m0_axi_awprot = 3'd0; m0_axi_awlen = 8'd0; m0_axi_awburst = 2'd1;
    m1_axi_awsize = 3'd3; m1_axi_awprot = 3'd0; m1_axi_awlen = 8'd0; m1_axi_awburst = 2'd1;
    m0_axi_arsize = 3'd3; m0_axi_arprot = 3'd0; m0_axi_arlen = 8'd0; m0_axi_arburst = 2'd1;
    m1_axi_arsize = 3'd3; m1_axi_arprot = 3'd0; m1_axi_arlen = 8'd0; m1_axi_arburst = 2'd1;
    m0_axi_wstrb = 8'hff; m0_axi_wlast = 1'b1; m1_axi_wstrb = 8'hff; m1_axi_wlast = 1'b1;
    {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid, axi_rlast} = '0;
    axi_bid = '0; axi_bresp = '0; axi_rid = '0; axi_rresp = '0; axi_rdata = 64'h1234_5678_9abc_def0;

    // Held in reset with requests pending: nothing may move.
    m0_axi_awvalid = 1'b1; m0_axi_wvalid = 1'b1; m0_axi_arvalid = 1'b1;
    axi_bvalid = 1'b1; axi_rvalid = 1'b1; axi_awready = 1'b1; axi_arready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_axi_awvalid", axi_awvalid, 1'b0);
    chk("rst_axi_wvalid", axi_wvalid, 1'b0);
    chk("rst_axi_arvalid", axi_arvalid, 1'b0);
    chk("rst_m0_awready", m0_axi_awready, 1'b0);
    chk("rst_m0_bvalid", m0_axi_bvalid, 1'b0);
    chk("rst_m0_rvalid", m0_axi_rvalid, 1'b0);
    m0_axi_awvalid = 1'b0; m0_axi_wvalid = 1'b0; m0_axi_arvalid = 1'b0;
    axi_bvalid = 1'b0; axi_rvalid = 1'b0;
    rst_l = 1'b1;
    step();

    // Response routing table.
    for (int i = 0; i < 5; i++) begin
      axi_bvalid = tbl[i].bv; axi_bid = tbl[i].bid; axi_bresp = tbl[i].bresp;
      axi_rvalid = tbl[i].rv; axi_rid = tbl[i].rid; axi_rresp = tbl[i].rresp;
      {m1_axi_rready, m0_axi_rready, m1_axi_bready, m0_axi_bready} = tbl[i].rdy;
      #1;
      chk($sformatf("rsp%0d_bvalid", i), {m1_axi_bvalid, m0_axi_bvalid}, tbl[i].e_bv);
      chk($sformatf("rsp%0d_rvalid", i), {m1_axi_rvalid, m0_axi_rvalid}, tbl[i].e_rv);
      chk($sformatf("rsp%0d_bready", i), axi_bready, tbl[i].e_bready);
      chk($sformatf("rsp%0d_rready", i), axi_rready, tbl[i].e_rready);
      chk($sformatf("rsp%0d_m0_bid", i), m0_axi_bid, tbl[i].e_bid);
      chk($sformatf("rsp%0d_m1_rid", i), m1_axi_rid, tbl[i].e_rid);
      chk($sformatf("rsp%0d_m1_rresp", i), m1_axi_rresp, tbl[i].e_rresp);
    end
    axi_bvalid = 1'b0; axi_rvalid = 1'b0;
    {m1_axi_rready, m0_axi_rready, m1_axi_bready, m0_axi_bready} = '0;
    axi_awready = 1'b1; axi_wready = 1'b1; axi_arready = 1'b1;

    // Simultaneous writes from reset: m0 first, then m1, then m0 wins next tie.
    wr(0, 1'b0, 32'h1000, 64'hd0); wr(1, 1'b0, 32'h2000, 64'hd1);
    #1 chk("no_comb_path_aw", axi_awvalid, 1'b0);
    step();
    chk("tie1_gnt_m0", axi_awid, 2'b00);
    chk("tie1_m1_awready", m1_axi_awready, 1'b0);
    chk("fwd_awlen", axi_awlen, 8'd0);
    chk("fwd_wstrb", axi_wstrb, 8'hff);
    chk("fwd_wlast", axi_wlast, 1'b1);
    step();
    chk("tie1_idle_gap", axi_awvalid, 1'b0);
    step();
    chk("tie1_gnt_m1", axi_awid, 2'b10);
    step();
    wr(0, 1'b1, 32'h1010, 64'hd2); wr(1, 1'b1, 32'h2010, 64'hd3);
    step();
    chk("tie2_gnt_m0", axi_awid, 2'b01);
    step(); step();
    chk("tie2_gnt_m1", axi_awid, 2'b11);
    step();

    // Address accepted early, data accepted three cycles later.
    axi_wready = 1'b0;
    wr(0, 1'b0, 32'h3000, 64'hd4);
    step();
    chk("split_awvalid", axi_awvalid, 1'b1);
    chk("split_wvalid", axi_wvalid, 1'b1);
    step();
    chk("split_no_dup_aw", axi_awvalid, 1'b0);
    chk("split_wvalid_held", axi_wvalid, 1'b1);
    chk("split_m0_awready", m0_axi_awready, 1'b0);
    step(); step();
    chk("split_no_dup_aw2", axi_awvalid, 1'b0);
    axi_wready = 1'b1;
    #1 chk("split_m0_wready", m0_axi_wready, 1'b1);
    step();
    chk("split_idle_wvalid", axi_wvalid, 1'b0);
    chk("split_idle_awvalid", axi_awvalid, 1'b0);

    // Write from m0 and read from m1 proceed in parallel.
    wr(0, 1'b1, 32'h4000, 64'hd5); rd(1, 1'b0, 32'h5000);
    #1 chk("no_comb_path_ar", axi_arvalid, 1'b0);
    step();
    chk("par_awvalid", axi_awvalid, 1'b1);
    chk("par_arvalid", axi_arvalid, 1'b1);
    chk("par_arid", axi_arid, 2'b10);
    step();
    chk("par_done_aw", axi_awvalid, 1'b0);
    chk("par_done_ar", axi_arvalid, 1'b0);

    // Address without data from m1 must not be granted.
    m1_axi_awvalid = 1'b1; m1_axi_awid = 1'b1; m1_axi_awaddr = 32'h6000; m1_axi_awburst = 2'd2;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("awonly_no_gnt%0d", c), axi_awvalid, 1'b0);
    end
    m1_axi_wvalid = 1'b1; m1_axi_wdata = 64'hd7;
    q_aw.push_back({1'b1, 1'b1, 32'h6000}); q_w.push_back(64'hd7);
    #1 chk("awonly_wvalid_no_comb", axi_awvalid, 1'b0);
    step();
    chk("awonly_gnt", axi_awvalid, 1'b1);
    chk("fwd_awburst_m1", axi_awburst, 2'd2);
    step();
    m1_axi_awburst = 2'd1;

    // Read tie: last read went to m1, so m0 wins.
    rd(0, 1'b1, 32'h7000); rd(1, 1'b1, 32'h8000);
    step();
    chk("rd_tie_m0", axi_arid, 2'b01);
    step(); step();
    chk("rd_tie_m1", axi_arid, 2'b11);
    step();

    // Reset after the address handshake abandons the write.
    axi_wready = 1'b0;
    wr(0, 1'b0, 32'h9000, 64'hda);
    step(); step();
    chk("abort_pre_awvalid", axi_awvalid, 1'b0);
    chk("abort_pre_wvalid", axi_wvalid, 1'b1);
    rst_l = 1'b0; axi_wready = 1'b1;
    #1;
    chk("abort_async_wvalid", axi_wvalid, 1'b0);
    chk("abort_m0_wready", m0_axi_wready, 1'b0);
    m0_axi_awvalid = 1'b0; m0_axi_wvalid = 1'b0;
    void'(q_w.pop_back());
    @(posedge clk);
    #1;
    chk("abort_held_wvalid", axi_wvalid, 1'b0);
    rst_l = 1'b1;
    wr(0, 1'b0, 32'ha000, 64'hdb); wr(1, 1'b0, 32'hb000, 64'hdc);
    step();
    chk("post_rst_tie_m0", axi_awid, 2'b00);
    step(); step();
    chk("post_rst_m1", axi_awid, 2'b10);
    step();

    chk("q_aw_drained", q_aw.size(), 0);
    chk("q_w_drained", q_w.size(), 0);
    chk("q_ar_drained", q_ar.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
